dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 (core load/store unit) and port 1 (aux: DMA/debug loader).
- Arbitrates round-robin, checks alignment and range before driving memory, and returns registered responses.
- Supports an aux burst lock.
- Sits between the requesters and data_memory. It drives the memory's w_en, r_en, op_sel, addr and data_w, and samples its combinational data_r.

Parameters:
- DMEM_DEPTH, 256, number of 32-bit words in the attached memory; used for the range check.
- ADDR_W, 32, byte-address width of the request ports.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit 0 = core, bit 1 = aux.
- req_ready  out  2  per-port accept; a transfer occurs when valid & ready at posedge.
- req_we  in  2  per-port write enable (1 = store, 0 = load).
- req_funct3  in  2x3  per-port RISC-V funct3 (lb/lh/lw/lbu/lhu, sb/sh/sw).
- req_addr  in  2xADDR_W  per-port byte address.
- req_wdata  in  2x32  per-port store data.
- aux_lock  in  1  aux requests burst ownership.
- rsp_valid  out  2  per-port one-cycle response pulse.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  response carries misalign/range error.
- mem_w_en, mem_r_en  out  1 each  memory enables.
- mem_op_sel  out  3  funct3 to memory.
- mem_addr  out  32  byte address to memory.
- mem_data_w  out  32  store data to memory.
- mem_data_r  in  32  combinational read data from memory.

Behaviour:
- Reset (async, rst=1): state=ARB, last_grant=1 (so core wins first), rsp_valid=0, rsp_rdata=0, rsp_err=0. All mem_* outputs are 0 while in reset and while no grant is active.
- Any pending response is discarded on reset mid-operation. No memory write occurs in a cycle where rst is high.
- Grant is combinational, at most one port per cycle:
  - state ARB, one valid: grant that port.
  - state ARB, both valid: grant the port != last_grant.
  - state LOCK_AUX: only aux may be granted; core req_ready=0.
- req_ready[i] = grant[i]. The requester must hold its payload stable while valid and not ready.
- On a granted, legal request, mem_* are driven from the granted port in the same cycle:
  - mem_w_en = we; mem_r_en = ~we.
  - A store commits at that posedge.
  - A load's mem_data_r is captured into rsp_rdata at that posedge.
- Error checks, evaluated on the granted request:
  - misaligned: lw/sw with addr[1:0]!=0; lh/lhu/sh with addr[0]!=0.
  - out of range: addr[31:2] >= DMEM_DEPTH.
  - illegal funct3: 011, 110, 111, and store funct3 > 010.
  - On any error: the request is still accepted, mem_w_en=mem_r_en=0, rsp_err=1, rsp_rdata=0.
- Response:
  - rsp_valid[i] pulses exactly one cycle after acceptance on port i. Latency is 1; throughput is 1 request per cycle.
  - There is no response backpressure; requesters must always sink responses.
  - Store responses have rdata=0, err=0.
- last_grant updates to the accepted port on each transfer.
- FSM transitions:
  - ARB->LOCK_AUX when aux is accepted with aux_lock=1.
  - LOCK_AUX->ARB at the first cycle aux_lock=0, evaluated before grant; that cycle arbitrates normally.
  - While in LOCK_AUX with aux idle, no grant is given; core waits.
- Simultaneous core/aux requests to the same word: only one is granted per cycle, so there is no collision.

Optional Feature:
- DMEM_ARB_STATS_EN defined: adds outputs stat_grants_core and stat_grants_aux (16 bits each, saturating, +1 per accepted request), stat_errors (16 bits, saturating), and stat_stall_core (16 bits, saturating, +1 per cycle with core valid and not ready). All reset to 0.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - typedef dmem_req_t {we, funct3, addr, wdata}.
  - typedef dmem_rsp_t {rdata, err}.
  - enum arb_state_e {ARB, LOCK_AUX}.
- One sub-module, dmem_req_check: combinational misalign, range and illegal-funct3 detection, parameterised by DMEM_DEPTH.

Test Plan:
- Core lw addr 0x10, memory word 4 = 0xCAFEBABE -> req_ready[0]=1 same cycle; next cycle rsp_valid=2'b01, rsp_rdata=0xCAFEBABE, err=0.
- Both ports valid continuously with 4 requests each -> grants alternate core, aux, core, aux…, starting with core after reset; rsp_valid pulses follow, one cycle behind.
- Core sw addr 0x22 (misaligned) -> accepted, mem_w_en=0, word 8 unchanged, next cycle rsp_err=1, rsp_rdata=0. Also core lw addr 4*DMEM_DEPTH -> rsp_err=1.
- Aux asserts aux_lock over 3 sb writes while core is also valid -> core req_ready=0 for all 3; core is granted the cycle after aux_lock drops.
- Aux sb 0xAB to addr 0x05, then aux lbu addr 0x05 -> rsp_rdata=0x000000AB; lb of 0x80 stored -> 0xFFFFFF80.
- Assert rst the cycle after a load is accepted -> rsp_valid stays 0, state=ARB, the next both-valid cycle grants core.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory arbiter slice.
//   - RISC-V load/store funct3 encodings (F3_*)
//   - dmem_req_t : one requester's payload {we, funct3, addr, wdata}
//   - dmem_rsp_t : registered response payload {rdata, err}
//   - arb_state_e: arbiter FSM states
//   - sat_inc    : saturating increment for the optional statistics counters
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int STAT_W = 16;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_rsp_t;

    typedef enum logic {
        ARB      = 1'b0,
        LOCK_AUX = 1'b1
    } arb_state_e;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                  input logic              en);
        return (en && (v != '1)) ? v + STAT_W'(1) : v;
    endfunction

endpackage

// File: rtl/dmem_req_check.sv
// -----------------------------------------------------------------------------
// dmem_req_check
// Purely combinational legality check of one load/store request.
// Ports:
//   we           in   1 = store, 0 = load
//   funct3       in   RISC-V funct3 of the access
//   addr         in   byte address (ADDR_W bits)
//   misaligned   out  word access not 4-aligned / half access not 2-aligned
//   out_of_range out  word index addr[ADDR_W-1:2] >= DMEM_DEPTH
//   illegal_f3   out  reserved funct3 (011/110/111) or unsigned store form
// -----------------------------------------------------------------------------
module dmem_req_check
    import dmem_pkg::*;
#(
    parameter int DMEM_DEPTH = 256,
    parameter int ADDR_W     = 32
) (
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    output logic              misaligned,
    output logic              out_of_range,
    output logic              illegal_f3
);

    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DMEM_DEPTH);

    logic [ADDR_W-1:0] word_idx;

    assign word_idx     = addr >> 2;
    assign out_of_range = (word_idx >= DEPTH_LIM);

    // Stores only exist in the signed encodings sb/sh/sw (funct3 <= 010).
    assign illegal_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                        (funct3 == 3'b111) || (we && (funct3 > F3_W));

    always_comb begin
        misaligned = 1'b0;
        case (funct3)
            F3_W:        misaligned = (addr[1:0] != 2'b00);
            F3_H, F3_HU: misaligned = addr[0];
            default:     misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data-memory port between the core LSU (port 0) and an aux
// requester (port 1, DMA/debug loader). Round-robin grant, optional aux burst
// lock, legality check before touching memory, 1-cycle registered response.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready[1:0] per-port handshake (bit 0 core, bit 1 aux)
//   req_we, req_funct3, req_addr, req_wdata   per-port request payload
//   aux_lock                 aux asks to keep ownership across a burst
//   rsp_valid[1:0]           one-cycle response pulse, one cycle after accept
//   rsp_rdata, rsp_err       load data (0 for stores/errors), error flag
//   mem_w_en, mem_r_en, mem_op_sel, mem_addr, mem_data_w   to data_memory
//   mem_data_r               combinational read data from data_memory
//
// Optional build macro DMEM_ARB_STATS_EN adds saturating 16-bit counters:
//   stat_grants_core, stat_grants_aux, stat_errors, stat_stall_core.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DMEM_DEPTH = 256,
    parameter int ADDR_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][2:0]        req_funct3,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]       req_wdata,
    input  logic                   aux_lock,
    output logic [1:0]             rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   mem_w_en,
    output logic                   mem_r_en,
    output logic [2:0]             mem_op_sel,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_data_w,
    input  logic [31:0]            mem_data_r
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]      stat_grants_core,
    output logic [STAT_W-1:0]      stat_grants_aux,
    output logic [STAT_W-1:0]      stat_errors,
    output logic [STAT_W-1:0]      stat_stall_core
`endif
);

    arb_state_e  state_reg;
    arb_state_e  state_next;
    arb_state_e  eff_state;
    logic        last_grant_reg;
    logic [1:0]  grant;

    dmem_req_t   req_pkt [2];
    logic [1:0]  port_err;
    dmem_req_t   sel_req;
    logic        sel_err;
    logic        xfer;
    logic        legal;

    dmem_rsp_t   rsp_next;
    dmem_rsp_t   rsp_reg;
    logic [1:0]  rsp_valid_reg;

    // -------------------------------------------------------------------------
    // Per-port payload packing and legality check. The memory address bus is
    // 32 bits wide, so the packed address is resized to 32; the range check
    // still sees the full ADDR_W-bit address.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic mis;
            logic oor;
            logic ill;

            assign req_pkt[gi] = '{we:     req_we[gi],
                                   funct3: req_funct3[gi],
                                   addr:   32'(req_addr[gi]),
                                   wdata:  req_wdata[gi]};

            dmem_req_check #(
                .DMEM_DEPTH (DMEM_DEPTH),
                .ADDR_W     (ADDR_W)
            ) u_check (
                .we           (req_we[gi]),
                .funct3       (req_funct3[gi]),
                .addr         (req_addr[gi]),
                .misaligned   (mis),
                .out_of_range (oor),
                .illegal_f3   (ill)
            );

            assign port_err[gi] = mis | oor | ill;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // FSM state register and last-grant pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ARB;
            last_grant_reg <= 1'b1;     // pretend aux went last so core wins first
        end else begin
            state_reg <= state_next;
            if (xfer) begin
                last_grant_reg <= grant[1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Grant and next-state. Dropping aux_lock releases the lock in the same
    // cycle, so that cycle already arbitrates as ARB (eff_state).
    // -------------------------------------------------------------------------
    always_comb begin
        eff_state = state_reg;
        if ((state_reg == LOCK_AUX) && !aux_lock) begin
            eff_state = ARB;
        end

        grant = 2'b00;
        if (!rst) begin
            if (eff_state == LOCK_AUX) begin
                grant = {req_valid[1], 1'b0};
            end else if (&req_valid) begin
                grant = last_grant_reg ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end

        state_next = eff_state;
        if (grant[1] && aux_lock) begin
            state_next = LOCK_AUX;
        end
    end

    assign req_ready = grant;

    // -------------------------------------------------------------------------
    // Memory drive: only a granted, legal request reaches the memory. Errored
    // requests are still accepted but leave every mem_* signal at 0.
    // -------------------------------------------------------------------------
    assign sel_req = grant[1] ? req_pkt[1] : req_pkt[0];
    assign sel_err = grant[1] ? port_err[1] : port_err[0];
    assign xfer    = |grant;
    assign legal   = xfer && !sel_err;

    assign mem_w_en   = legal &&  sel_req.we;
    assign mem_r_en   = legal && !sel_req.we;
    assign mem_op_sel = legal ? sel_req.funct3 : 3'b000;
    assign mem_addr   = legal ? sel_req.addr   : 32'h0;
    assign mem_data_w = legal ? sel_req.wdata  : 32'h0;

    // -------------------------------------------------------------------------
    // Registered response
    // -------------------------------------------------------------------------
    always_comb begin
        rsp_next.rdata = mem_r_en ? mem_data_r : 32'h0;
        rsp_next.err   = xfer && sel_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg <= 2'b00;
            rsp_reg       <= '0;
        end else begin
            rsp_valid_reg <= grant;
            rsp_reg       <= rsp_next;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_reg.rdata;
    assign rsp_err   = rsp_reg.err;

`ifdef DMEM_ARB_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating statistics counters
    // -------------------------------------------------------------------------
    logic [STAT_W-1:0] stat_core_reg;
    logic [STAT_W-1:0] stat_aux_reg;
    logic [STAT_W-1:0] stat_err_reg;
    logic [STAT_W-1:0] stat_stall_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_core_reg  <= '0;
            stat_aux_reg   <= '0;
            stat_err_reg   <= '0;
            stat_stall_reg <= '0;
        end else begin
            stat_core_reg  <= sat_inc(stat_core_reg,  grant[0]);
            stat_aux_reg   <= sat_inc(stat_aux_reg,   grant[1]);
            stat_err_reg   <= sat_inc(stat_err_reg,   xfer && sel_err);
            stat_stall_reg <= sat_inc(stat_stall_reg, req_valid[0] && !grant[0]);
        end
    end

    assign stat_grants_core = stat_core_reg;
    assign stat_grants_aux  = stat_aux_reg;
    assign stat_errors      = stat_err_reg;
    assign stat_stall_core  = stat_stall_reg;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a small byte-lane data_memory model
// (synchronous write, combinational sign/zero-extending read).
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int DEPTH = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][2:0]  req_funct3;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic             aux_lock;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             mem_w_en;
    logic             mem_r_en;
    logic [2:0]       mem_op_sel;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data_w;
    logic [31:0]      mem_data_r;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]      stat_grants_core, stat_grants_aux, stat_errors, stat_stall_core;
`endif

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(.DMEM_DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .aux_lock   (aux_lock),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_w_en   (mem_w_en),
        .mem_r_en   (mem_r_en),
        .mem_op_sel (mem_op_sel),
        .mem_addr   (mem_addr),
        .mem_data_w (mem_data_w),
        .mem_data_r (mem_data_r)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_grants_core (stat_grants_core),
        .stat_grants_aux  (stat_grants_aux),
        .stat_errors      (stat_errors),
        .stat_stall_core  (stat_stall_core)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- data_memory model ----------------
    logic [31:0] mem [DEPTH];
    logic        tb_we;
    logic [7:0]  tb_idx;
    logic [31:0] tb_data;
    logic [31:0] rd_word;
    logic [7:0]  rd_b;
    logic [15:0] rd_h;

    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_idx] <= tb_data;
        end else if (mem_w_en) begin
            case (mem_op_sel)
                F3_B:    mem[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8]  <= mem_data_w[7:0];
                F3_H:    mem[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_data_w[15:0];
                default: mem[mem_addr[9:2]] <= mem_data_w;
            endcase
        end
    end

    always_comb begin
        rd_word = mem[mem_addr[9:2]];
        rd_b    = rd_word[{mem_addr[1:0], 3'b000} +: 8];
        rd_h    = rd_word[{mem_addr[1], 4'b0000} +: 16];
        case (mem_op_sel)
            F3_B:    mem_data_r = {{24{rd_b[7]}}, rd_b};
            F3_H:    mem_data_r = {{16{rd_h[15]}}, rd_h};
            F3_BU:   mem_data_r = {24'h0, rd_b};
            F3_HU:   mem_data_r = {16'h0, rd_h};
            default: mem_data_r = rd_word;
        endcase
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid[p]  = v;
        req_we[p]     = we;
        req_funct3[p] = f3;
        req_addr[p]   = a;
        req_wdata[p]  = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic log_rsp(input string what);
        $display("[%0t] %s -> rsp_valid=%b rdata=%h err=%b", $time, what, rsp_valid, rsp_rdata, rsp_err);
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        tb_we   = 1'b1;
        tb_idx  = idx;
        tb_data = d;
        next_cycle();
        tb_we   = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    logic [1:0] exp_g;
    int         core_n;
    int         aux_n;

    initial begin
        rst = 1'b1; aux_lock = 1'b0; tb_we = 1'b0; tb_idx = '0; tb_data = '0;
        req_valid = '0; req_we = '0; req_funct3 = '0; req_addr = '0; req_wdata = '0;

        preload(8'd1, 32'h0000_0000);
        preload(8'd4, 32'hCAFE_BABE);
        preload(8'd8, 32'h1122_3344);

        // Reset holds everything quiet even with a request pending.
        drive(0, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        #1;
        chk("rst_ready",     32'(req_ready), 32'h0);
        chk("rst_mem_r_en",  32'(mem_r_en),  32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_rsp_err",   32'(rsp_err),   32'h0);

        // Core lw 0x10 -> word 4.
        next_cycle();
        rst = 1'b0;
        #1;
        chk("lw_ready",    32'(req_ready),  32'h1);
        chk("lw_mem_r_en", 32'(mem_r_en),   32'h1);
        chk("lw_mem_w_en", 32'(mem_w_en),   32'h0);
        chk("lw_mem_addr", mem_addr,        32'h10);
        chk("lw_op_sel",   32'(mem_op_sel), 32'(F3_W));
        next_cycle();
        chk("lw_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("lw_rsp_rdata", rsp_rdata,      32'hCAFE_BABE);
        chk("lw_rsp_err",   32'(rsp_err),   32'h0);
        log_rsp("core lw 0x10");
        drive(0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);

        // Fresh reset, then both ports busy: core, aux, core, aux ...
        rst = 1'b1;
        #2;
        rst = 1'b0;
        next_cycle();
        core_n = 0;
        aux_n  = 0;
        for (int k = 0; k < 8; k++) begin
            drive(0, core_n < 4, 1'b0, F3_W, 32'h10, 32'h0);
            drive(1, aux_n < 4,  1'b0, F3_W, 32'h20, 32'h0);
            #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("alt_grant", 32'(req_ready), 32'(exp_g));
            if (exp_g[0]) core_n++; else aux_n++;
            next_cycle();
            chk("alt_rsp_valid", 32'(rsp_valid), 32'(exp_g));
            chk("alt_rsp_rdata", rsp_rdata, exp_g[0] ? 32'hCAFE_BABE : 32'h1122_3344);
            log_rsp(exp_g[0] ? "alt core lw 0x10" : "alt aux lw 0x20");
        end
        drive(0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);

        // Misaligned sw 0x22: accepted, no write, error response.
        drive(0, 1'b1, 1'b1, F3_W, 32'h22, 32'hDEAD_BEEF);
        #1;
        chk("mis_ready",    32'(req_ready), 32'h1);
        chk("mis_mem_w_en", 32'(mem_w_en),  32'h0);
        next_cycle();
        chk("mis_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("mis_rsp_err",   32'(rsp_err),   32'h1);
        chk("mis_rsp_rdata", rsp_rdata,      32'h0);
        chk("mis_word8",     mem[8],         32'h1122_3344);
        log_rsp("core sw 0x22 (misaligned)");

        // Out of range: first word past the end.
        drive(0, 1'b1, 1'b0, F3_W, 32'(4 * DEPTH), 32'h0);
        #1;
        chk("oor_ready",    32'(req_ready), 32'h1);
        chk("oor_mem_r_en", 32'(mem_r_en),  32'h0);
        next_cycle();
        chk("oor_rsp_err",   32'(rsp_err), 32'h1);
        chk("oor_rsp_rdata", rsp_rdata,    32'h0);
        log_rsp("core lw 4*DEPTH (range)");

        // Last legal word is in range.
        drive(0, 1'b1, 1'b0, F3_W, 32'(4 * DEPTH - 4), 32'h0);
        #1;
        chk("last_mem_r_en", 32'(mem_r_en), 32'h1);
        next_cycle();
        chk("last_rsp_err", 32'(rsp_err), 32'h0);
        log_rsp("core lw 4*DEPTH-4");

        // Unsigned store encoding is illegal.
        drive(0, 1'b1, 1'b1, F3_BU, 32'h0, 32'h55);
        #1;
        chk("ill_mem_w_en", 32'(mem_w_en), 32'h0);
        next_cycle();
        chk("ill_rsp_err", 32'(rsp_err), 32'h1);
        log_rsp("core store funct3=100 (illegal)");

        // Aux burst lock: core keeps asking, aux owns the port (last grant was core).
        aux_lock = 1'b1;
        drive(0, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b1, F3_B, 32'h05, 32'h0000_00AB);
        #1;
        chk("lock1_ready", 32'(req_ready),  32'h2);
        chk("lock1_w_en",  32'(mem_w_en),   32'h1);
        chk("lock1_op",    32'(mem_op_sel), 32'(F3_B));
        next_cycle();
        chk("lock1_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("lock1_rsp_rdata", rsp_rdata,      32'h0);
        chk("lock1_rsp_err",   32'(rsp_err),   32'h0);
        log_rsp("aux sb 0x05=AB (lock)");
        drive(1, 1'b1, 1'b1, F3_B, 32'h06, 32'h0000_0080);
        #1;
        chk("lock2_ready", 32'(req_ready), 32'h2);
        next_cycle();
        chk("lock2_rsp_valid", 32'(rsp_valid), 32'h2);
        log_rsp("aux sb 0x06=80 (lock)");
        drive(1, 1'b0, 1'b0, F3_B, 32'h0, 32'h0);
        #1;
        chk("lock_idle_ready", 32'(req_ready), 32'h0);
        next_cycle();
        chk("lock_idle_rsp_valid", 32'(rsp_valid), 32'h0);
        log_rsp("aux idle under lock");
        drive(1, 1'b1, 1'b1, F3_B, 32'h07, 32'h0000_0012);
        #1;
        chk("lock3_ready", 32'(req_ready), 32'h2);
        next_cycle();
        chk("lock3_rsp_valid", 32'(rsp_valid), 32'h2);
        log_rsp("aux sb 0x07=12 (lock)");
        aux_lock = 1'b0;
        drive(1, 1'b0, 1'b0, F3_B, 32'h0, 32'h0);
        #1;
        chk("unlock_ready", 32'(req_ready), 32'h1);
        next_cycle();
        chk("unlock_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("unlock_rsp_rdata", rsp_rdata,      32'hCAFE_BABE);
        log_rsp("core lw 0x10 after unlock");
        drive(0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);

        // Aux read-back of the bytes just written.
        drive(1, 1'b1, 1'b0, F3_BU, 32'h05, 32'h0);
        next_cycle();
        chk("lbu_rdata", rsp_rdata, 32'h0000_00AB);
        log_rsp("aux lbu 0x05");
        drive(1, 1'b1, 1'b0, F3_B, 32'h06, 32'h0);
        next_cycle();
        chk("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
        log_rsp("aux lb 0x06");
        drive(1, 1'b1, 1'b0, F3_HU, 32'h06, 32'h0);
        next_cycle();
        chk("lhu_rdata", rsp_rdata, 32'h0000_1280);
        log_rsp("aux lhu 0x06");
        drive(1, 1'b1, 1'b0, F3_W, 32'h04, 32'h0);
        next_cycle();
        chk("lw1_rdata", rsp_rdata, 32'h1280_AB00);
        log_rsp("aux lw 0x04");

        // Aux load accepted under lock, then reset lands before its response is used.
        aux_lock = 1'b1;
        drive(1, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        #1;
        chk("prerst_ready", 32'(req_ready), 32'h2);
        next_cycle();
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst_rsp_rdata", rsp_rdata,      32'h0);
        log_rsp("reset after aux lw accepted");
        #2;
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, F3_W, 32'h20, 32'h0);
        #1;
        chk("postrst_ready", 32'(req_ready), 32'h1);
        next_cycle();
        chk("postrst_rsp_valid", 32'(rsp_valid), 32'h1);
        log_rsp("both valid after reset");
        req_valid = 2'b00;
        aux_lock  = 1'b0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
